// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle for pc_sequencer: run/stall/redirect inputs and fetch/flush outputs.
// master = sequencer side, slave = environment (branch unit, imem, back end).
interface pc_sequencer_if;
   logic        enable_i;
   logic        stall_i;
   logic        fetchReady_i;
   logic        branchTaken_i;
   logic [15:0] branchTarget_i;
   logic [15:0] pc_o;
   logic        fetchValid_o;
   logic        flush_o;
   logic        busy_o;

   modport master (
      input  enable_i, stall_i, fetchReady_i, branchTaken_i, branchTarget_i,
      output pc_o, fetchValid_o, flush_o, busy_o
   );

   modport slave (
      output enable_i, stall_i, fetchReady_i, branchTaken_i, branchTarget_i,
      input  pc_o, fetchValid_o, flush_o, busy_o
   );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: advances PC on accepted fetches, loads branch targets and runs a
// fixed-length flush. Optional redirect/flush statistics under PC_SEQ_BRANCH_STATS_EN.
module pc_sequencer #(
   parameter int unsigned FLUSH_CYCLES = 4,
   parameter logic [15:0] RESET_PC     = 16'h0000
) (
   input  logic               clock_i,
   input  logic               reset_i,
   pc_sequencer_if.master     bus
`ifdef PC_SEQ_BRANCH_STATS_EN
   ,
   output logic [15:0]        redirectCount_o,
   output logic [15:0]        flushCycleCount_o
`endif
);

   localparam int unsigned PC_W  = 16;
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fetch_valid_q, fetch_valid_d;
   logic             flush_q, flush_d;
   logic             busy_q, busy_d;

   // Next-state: redirect outranks the fetch handshake; enable low freezes everything.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      cnt_d         = cnt_q;
      fetch_valid_d = fetch_valid_q;
      flush_d       = flush_q;
      busy_d        = busy_q;
      if (bus.enable_i) begin
         case (state_q)
            ST_IDLE: begin
               state_d       = ST_RUN;
               fetch_valid_d = 1'b1;
            end
            ST_RUN: begin
               if (bus.branchTaken_i) begin
                  state_d       = ST_FLUSH;
                  pc_d          = bus.branchTarget_i;
                  cnt_d         = FLUSH_LOAD;
                  flush_d       = 1'b1;
                  busy_d        = 1'b1;
                  fetch_valid_d = 1'b0;
               end else if (fetch_valid_q && bus.fetchReady_i && !bus.stall_i) begin
                  pc_d = pc_q + PC_W'(1);
               end
            end
            ST_FLUSH: begin
               if (cnt_q == '0) begin
                  state_d       = ST_RUN;
                  flush_d       = 1'b0;
                  busy_d        = 1'b0;
                  fetch_valid_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         cnt_q         <= '0;
         fetch_valid_q <= 1'b0;
         flush_q       <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         cnt_q         <= cnt_d;
         fetch_valid_q <= fetch_valid_d;
         flush_q       <= flush_d;
         busy_q        <= busy_d;
      end
   end

   assign bus.pc_o         = pc_q;
   assign bus.fetchValid_o = fetch_valid_q;
   assign bus.flush_o      = flush_q;
   assign bus.busy_o       = busy_q;

`ifdef PC_SEQ_BRANCH_STATS_EN
   localparam int unsigned STAT_W = 16;

   logic [STAT_W-1:0] redirect_count_q, redirect_count_d;
   logic [STAT_W-1:0] flush_cycle_count_q, flush_cycle_count_d;
   logic              redirect_c;

   assign redirect_c = bus.enable_i && (state_q == ST_RUN) && bus.branchTaken_i;

   // Saturating event counters, frozen while disabled.
   always_comb begin
      redirect_count_d    = redirect_count_q;
      flush_cycle_count_d = flush_cycle_count_q;
      if (redirect_c && (redirect_count_q != '1)) begin
         redirect_count_d = redirect_count_q + STAT_W'(1);
      end
      if (bus.enable_i && flush_q && (flush_cycle_count_q != '1)) begin
         flush_cycle_count_d = flush_cycle_count_q + STAT_W'(1);
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         redirect_count_q    <= '0;
         flush_cycle_count_q <= '0;
      end else begin
         redirect_count_q    <= redirect_count_d;
         flush_cycle_count_q <= flush_cycle_count_d;
      end
   end

   assign redirectCount_o   = redirect_count_q;
   assign flushCycleCount_o = flush_cycle_count_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized run,
// all compared against a cycle-level behavioural model of the fetch sequencer.
module tb_pc_sequencer;

   localparam int unsigned FC = 4;

   logic clock_i;
   logic reset_i;
   pc_sequencer_if bus ();

   int errors;
   int checks;

   // Behavioural model: started flag, PC, remaining flush cycles, fetch-valid.
   bit          m_started;
   logic [15:0] m_pc;
   int          m_flush_left;
   bit          m_valid;

`ifdef PC_SEQ_BRANCH_STATS_EN
   logic [15:0] redirectCount_o;
   logic [15:0] flushCycleCount_o;
   int          m_redir;
   int          m_fcyc;

   pc_sequencer #(.FLUSH_CYCLES(FC), .RESET_PC(16'h0000)) dut (
      .clock_i(clock_i), .reset_i(reset_i), .bus(bus),
      .redirectCount_o(redirectCount_o), .flushCycleCount_o(flushCycleCount_o));
`else
   pc_sequencer #(.FLUSH_CYCLES(FC), .RESET_PC(16'h0000)) dut (
      .clock_i(clock_i), .reset_i(reset_i), .bus(bus));
`endif

   initial clock_i = 1'b0;
   always #5 clock_i = ~clock_i;

   task automatic model_step();
      if (reset_i) begin
         m_started    = 1'b0;
         m_pc         = 16'h0000;
         m_flush_left = 0;
         m_valid      = 1'b0;
`ifdef PC_SEQ_BRANCH_STATS_EN
         m_redir = 0;
         m_fcyc  = 0;
`endif
      end else if (bus.enable_i) begin
`ifdef PC_SEQ_BRANCH_STATS_EN
         if (m_flush_left > 0 && m_fcyc < 65535) m_fcyc++;
`endif
         if (!m_started) begin
            m_started = 1'b1;
            m_valid   = 1'b1;
         end else if (m_flush_left > 0) begin
            m_flush_left--;
            if (m_flush_left == 0) m_valid = 1'b1;
         end else if (bus.branchTaken_i) begin
            m_pc         = bus.branchTarget_i;
            m_flush_left = FC;
            m_valid      = 1'b0;
`ifdef PC_SEQ_BRANCH_STATS_EN
            if (m_redir < 65535) m_redir++;
`endif
         end else if (bus.fetchReady_i && !bus.stall_i) begin
            m_pc = m_pc + 16'd1;
         end
      end
   endtask

   // One clock: DUT and model see the same inputs; outputs settle 1 time unit later.
   task automatic tick();
      @(posedge clock_i);
      model_step();
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (bus.flush_o === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (bus.flush_o !== 1'b0) begin
         errors++;
         $display("FAIL drain_timeout: flush_o=%b after %0d cycles, want 0", bus.flush_o, n);
      end
   endtask

   task automatic redirect_to(input logic [15:0] target);
      bus.branchTaken_i  = 1'b1;
      bus.branchTarget_i = target;
      tick();
      bus.branchTaken_i  = 1'b0;
      drain();
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      bus.enable_i = 1'b1; bus.stall_i = 1'b0; bus.fetchReady_i = 1'b0;
      bus.branchTaken_i = 1'b0; bus.branchTarget_i = 16'h0000;
      tick(); tick();
      checks++;
      if (bus.pc_o !== 16'h0000) begin
         errors++; $display("FAIL reset_pc: got %h want 0000", bus.pc_o);
      end
      checks++;
      if ({bus.fetchValid_o, bus.flush_o, bus.busy_o} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got v/f/b=%b%b%b want 000",
                  bus.fetchValid_o, bus.flush_o, bus.busy_o);
      end
   endtask

   task automatic test_sequential();
      reset_i = 1'b0;
      bus.fetchReady_i = 1'b1;
      tick();
      checks++;
      if (bus.pc_o !== 16'h0000 || bus.fetchValid_o !== 1'b1) begin
         errors++;
         $display("FAIL idle_to_run: pc=%h valid=%b want 0000/1", bus.pc_o, bus.fetchValid_o);
      end
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++;
         if (bus.pc_o !== 16'(i) || bus.fetchValid_o !== 1'b1) begin
            errors++;
            $display("FAIL seq_pc%0d: pc=%h valid=%b want %h/1", i, bus.pc_o,
                     bus.fetchValid_o, 16'(i));
         end
      end
   endtask

   task automatic test_wrap();
      logic [15:0] exp_seq [3];
      exp_seq[0] = 16'hFFFE; exp_seq[1] = 16'hFFFF; exp_seq[2] = 16'h0000;
      redirect_to(16'hFFFE);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) tick();
         checks++;
         if (bus.pc_o !== exp_seq[i]) begin
            errors++; $display("FAIL wrap_%0d: pc=%h want %h", i, bus.pc_o, exp_seq[i]);
         end
      end
   endtask

   task automatic test_stall();
      redirect_to(16'h0010);
      bus.stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus.pc_o !== 16'h0010 || bus.fetchValid_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold%0d: pc=%h valid=%b want 0010/1", i, bus.pc_o,
                     bus.fetchValid_o);
         end
      end
      bus.stall_i = 1'b0;
      tick();
      checks++;
      if (bus.pc_o !== 16'h0011) begin
         errors++; $display("FAIL stall_release: pc=%h want 0011", bus.pc_o);
      end
   endtask

   task automatic test_redirect();
      int n = 0;
      bus.fetchReady_i   = 1'b1;
      bus.branchTaken_i  = 1'b1;
      bus.branchTarget_i = 16'h0040;
      tick();
      bus.branchTaken_i  = 1'b0;
      checks++;
      if (bus.pc_o !== 16'h0040 || {bus.fetchValid_o, bus.flush_o, bus.busy_o} !== 3'b011) begin
         errors++;
         $display("FAIL redirect_load: pc=%h v/f/b=%b%b%b want 0040/011", bus.pc_o,
                  bus.fetchValid_o, bus.flush_o, bus.busy_o);
      end
      while (bus.flush_o === 1'b1 && n < 40) begin
         n++;
         bus.branchTaken_i  = (n == 2);
         bus.branchTarget_i = 16'h0099;
         tick();
      end
      bus.branchTaken_i = 1'b0;
      checks++;
      if (n != FC) begin
         errors++; $display("FAIL flush_len: got %0d cycles want %0d", n, FC);
      end
      checks++;
      if (bus.pc_o !== 16'h0040 || bus.fetchValid_o !== 1'b1 || bus.busy_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_resume: pc=%h valid=%b busy=%b want 0040/1/0", bus.pc_o,
                  bus.fetchValid_o, bus.busy_o);
      end
      tick();
      checks++;
      if (bus.pc_o !== 16'h0041) begin
         errors++; $display("FAIL post_flush_fetch: pc=%h want 0041", bus.pc_o);
      end
   endtask

   task automatic test_reset_mid_flush();
      bus.branchTaken_i  = 1'b1;
      bus.branchTarget_i = 16'h0077;
      tick();
      bus.branchTaken_i  = 1'b0;
      tick();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      checks++;
      if (bus.pc_o !== 16'h0000 || {bus.fetchValid_o, bus.flush_o, bus.busy_o} !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid_flush: pc=%h v/f/b=%b%b%b want 0000/000", bus.pc_o,
                  bus.fetchValid_o, bus.flush_o, bus.busy_o);
      end
      tick();
      tick();
      checks++;
      if (bus.pc_o !== 16'h0001 || bus.flush_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_recover: pc=%h flush=%b want 0001/0", bus.pc_o, bus.flush_o);
      end
   endtask

   task automatic test_enable_gap();
      int n = 0;
      bus.branchTaken_i  = 1'b1;
      bus.branchTarget_i = 16'h0123;
      tick();
      bus.branchTaken_i  = 1'b0;
      while (bus.flush_o === 1'b1 && n < 40) begin
         n++;
         bus.enable_i = !(n == 2 || n == 3);
         tick();
      end
      bus.enable_i = 1'b1;
      checks++;
      if (n != FC + 2) begin
         errors++; $display("FAIL enable_gap_len: got %0d cycles want %0d", n, FC + 2);
      end
      checks++;
      if (bus.pc_o !== 16'h0123 || bus.fetchValid_o !== 1'b1) begin
         errors++;
         $display("FAIL enable_gap_resume: pc=%h valid=%b want 0123/1", bus.pc_o,
                  bus.fetchValid_o);
      end
   endtask

   task automatic test_stats();
`ifdef PC_SEQ_BRANCH_STATS_EN
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      tick();
      redirect_to(16'h0200);
      redirect_to(16'h0300);
      redirect_to(16'h0400);
      checks++;
      if (redirectCount_o !== 16'd3 || flushCycleCount_o !== 16'(3 * FC)) begin
         errors++;
         $display("FAIL stats: redirects=%0d flush_cycles=%0d want 3/%0d", redirectCount_o,
                  flushCycleCount_o, 3 * FC);
      end
`endif
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         reset_i            = ($urandom % 64) == 0;
         bus.enable_i       = ($urandom % 8) != 0;
         bus.stall_i        = ($urandom % 4) == 0;
         bus.fetchReady_i   = ($urandom % 4) != 0;
         bus.branchTaken_i  = ($urandom % 8) == 0;
         bus.branchTarget_i = 16'($urandom);
         tick();
         checks++;
         if ({bus.pc_o, bus.fetchValid_o, bus.flush_o, bus.busy_o} !==
             {m_pc, m_valid, m_flush_left > 0, m_flush_left > 0}) begin
            errors++;
            $display("FAIL random_c%0d: pc/v/f/b=%h/%b%b%b want %h/%b%b%b", i, bus.pc_o,
                     bus.fetchValid_o, bus.flush_o, bus.busy_o, m_pc, m_valid,
                     m_flush_left > 0, m_flush_left > 0);
         end
`ifdef PC_SEQ_BRANCH_STATS_EN
         checks++;
         if (redirectCount_o !== 16'(m_redir) || flushCycleCount_o !== 16'(m_fcyc)) begin
            errors++;
            $display("FAIL random_stats_c%0d: got %0d/%0d want %0d/%0d", i, redirectCount_o,
                     flushCycleCount_o, m_redir, m_fcyc);
         end
`endif
      end
      reset_i = 1'b0;
      bus.enable_i = 1'b1;
      bus.branchTaken_i = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_sequential();
      test_wrap();
      test_stall();
      test_redirect();
      test_reset_mid_flush();
      test_enable_gap();
      test_stats();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer and redirect controller for the fetch front end. Holds the architectural fetch PC, advances it on each accepted instruction-memory request, and on a taken branch from the branch unit loads the target and drives a multi-cycle flush of younger pipeline stages before fetch resumes. Sits between the branch unit (redirect source), instruction memory (fetch handshake) and the decode/issue stages (flush sinks).

## Interface
- FLUSH_CYCLES, 4, cycles `flush_o` is held after a redirect; legal range 1..15
- RESET_PC, 16'h0000, PC loaded on reset
- clock_i  input  1  single clock; all state changes on rising edge
- reset_i  input  1  synchronous, active-high reset
- enable_i  input  1  global run enable; low freezes all state (reset still wins)
- stall_i  input  1  back-end stall; blocks PC advance in RUN
- fetchReady_i  input  1  instruction memory accepts request this cycle
- branchTaken_i  input  1  one-cycle taken-branch pulse from branch unit
- branchTarget_i  input  16  redirect target, valid with `branchTaken_i`
- pc_o  output  16  current fetch address (registered)
- fetchValid_o  output  1  fetch request valid (registered)
- flush_o  output  1  kill younger stages (registered)
- busy_o  output  1  high while in FLUSH

## Operation
- States: IDLE, RUN, FLUSH; 4-bit flush counter.
- Reset (priority over everything): state IDLE, `pc_o`=RESET_PC, `fetchValid_o`=0, `flush_o`=0, `busy_o`=0, counter=0.
- `enable_i`=0: hold all registers, ignore all inputs except reset.
- IDLE: unconditionally -> RUN next enabled cycle; `fetchValid_o`<=1.
- RUN: handshake fires when `fetchValid_o` & `fetchReady_i` & ~`stall_i`; then `pc_o`<=`pc_o`+1 modulo 2^16 (16'hFFFF wraps to 0, no flag). `stall_i` high holds `pc_o` and keeps `fetchValid_o`=1.
- RUN with `branchTaken_i`: `pc_o`<=`branchTarget_i`, counter<=FLUSH_CYCLES-1, `flush_o`<=1, `busy_o`<=1, `fetchValid_o`<=0, -> FLUSH. Redirect beats a simultaneous handshake: no increment, target loaded exactly.
- FLUSH: counter decrements each enabled cycle regardless of `stall_i`; `branchTaken_i` ignored (branch is on the killed path). At counter=0: `flush_o`<=0, `busy_o`<=0, `fetchValid_o`<=1, -> RUN, `pc_o` unchanged (=target).
- `branchTaken_i` in IDLE ignored.

## Timing
- Redirect sampled at edge N: edges N+1..N+FLUSH_CYCLES show `flush_o`=1, `fetchValid_o`=0, `pc_o`=target; at edge N+FLUSH_CYCLES+1 `flush_o`=0, `fetchValid_o`=1.
- PC advance latency: handshake at edge N -> new `pc_o` visible after edge N.
- Reset asserted mid-FLUSH: next edge all outputs at reset values, flush aborted, counter cleared.
- `enable_i` low mid-FLUSH extends the flush by the number of disabled cycles.
- All outputs registered; no combinational input-to-output path.

## Configuration
- `PC_SEQ_BRANCH_STATS_EN` defined: adds outputs `redirectCount_o` (16) and `flushCycleCount_o` (16); increment on each accepted redirect and each cycle `flush_o`=1 respectively; saturate at 16'hFFFF; cleared by reset; frozen when `enable_i`=0.
- Undefined: ports and counters absent; core behaviour identical.

## Test plan
- Reset release, `fetchReady_i`=1, no stall: `pc_o` 0 held in IDLE one cycle, then 0,1,2,3 on successive edges with `fetchValid_o`=1.
- `pc_o`=16'hFFFE, ready held: next values 16'hFFFF then 16'h0000.
- `stall_i`=1 for 3 cycles at `pc_o`=16'h0010: `pc_o` holds 16'h0010, `fetchValid_o`=1; advances to 16'h0011 the cycle after stall drops.
- `branchTaken_i`=1, target 16'h0040, same cycle as handshake, FLUSH_CYCLES=4: `pc_o`=16'h0040 (not +1), `flush_o` high exactly 4 cycles, second `branchTaken_i` during flush ignored, fetch resumes at 16'h0040.
- `reset_i` pulsed in 2nd flush cycle: next edge `pc_o`=0, `flush_o`=0, state IDLE; `enable_i`=0 for 2 cycles mid-flush lengthens `flush_o` to 6 cycles.
- With `PC_SEQ_BRANCH_STATS_EN`: 3 redirects at FLUSH_CYCLES=4 -> `redirectCount_o`=3, `flushCycleCount_o`=12.
